// File: rtl/rr_channel_arbiter.sv
// N-channel valid/ready arbiter with round-robin or fixed-priority grant,
// merging all channels into one registered output beat tagged with its source.
module rr_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prio_mode,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;

  logic              can_load;
  logic              gnt_vld;
  logic              accept;
  logic [CH_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  int                cand;

  assign can_load = (state_q == EMPTY) || out_ready;
  assign accept   = gnt_vld && can_load;

  // Search from the farthest candidate back to the nearest so the nearest valid one wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = prio_mode ? off : (int'(ptr_q) + off) % NUM_CH;
      if (in_valid[CH_W'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_vld && (CH_W'(i) == gnt_idx)) begin
        in_ready[i] = can_load;
        gnt_data    = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = FULL;
      data_d  = gnt_data;
      ch_d    = gnt_idx;
      ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Bench for rr_channel_arbiter: directed scenarios plus randomized traffic
// checked against a beat-level reference model.
module tb_rr_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     prio_mode = 1'b0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: output register contents and next round-robin start point.
  bit         m_full = 1'b0;
  logic [7:0] m_data = '0;
  int         m_ch = 0;
  int         m_ptr = 0;

  rr_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .prio_mode(prio_mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int model_grant(input logic [3:0] v, input logic mode, input int ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = mode ? k : (ptr + k) % NUM_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant(in_valid, prio_mode, m_ptr);
    if (g >= 0 && (!m_full || out_ready)) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
  endtask

  task automatic tick();
    int g;
    bit acc;
    g   = model_grant(in_valid, prio_mode, m_ptr);
    acc = (g >= 0) && (!m_full || out_ready);
    @(posedge clk);
    if (acc) begin
      m_full = 1'b1;
      m_data = 8'(in_data >> (g * 8));
      m_ch   = g;
      m_ptr  = (g == NUM_CH - 1) ? 0 : g + 1;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", out_data); end
    tests_run++; if (out_ch !== 2'd0) begin tests_failed++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
    rst_n = 1'b1;
    #2;
    in_data = 32'h44332211; in_valid = 4'b0010; out_ready = 1'b0;
    #1 tick();
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin tests_failed++; $display("FAIL reset_prefill: valid=%b ch=%0d expected 1/1", out_valid, out_ch); end
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_ch !== 2'd0) begin tests_failed++; $display("FAIL async_reset_ch: got %0d expected 0", out_ch); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    in_valid = 4'b1111;
    #1;
    tests_run++; if (in_ready !== 4'b0001) begin tests_failed++; $display("FAIL reset_ptr: in_ready=%b expected 0001", in_ready); end
    in_valid = 4'b0100;
    #1;
    tests_run++; if (in_ready !== 4'b0100) begin tests_failed++; $display("FAIL reset_ch2_ready: in_ready=%b expected 0100", in_ready); end
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h33) begin tests_failed++; $display("FAIL reset_ch2_beat: valid=%b ch=%0d data=%h expected 1/2/33", out_valid, out_ch, out_data); end
  endtask

  task automatic test_round_robin();
    do_reset();
    prio_mode = 1'b0; in_data = 32'hA3A2A1A0; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_latency: out_valid=%b expected 0 before first edge", out_valid); end
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'(8'hA0 + k % 4)) begin
        tests_failed++;
        $display("FAIL rr_seq[%0d]: valid=%b ch=%0d data=%h expected 1/%0d/%h", k, out_valid, out_ch, out_data, k % 4, 8'hA0 + k % 4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    prio_mode = 1'b0; in_data = 32'hA3A2A1A0; in_valid = 4'b1111; out_ready = 1'b1;
    #1 tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++; if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL stall_ready[%0d]: in_ready=%b expected 0000", k, in_ready); end
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_ch !== 2'd1) begin tests_failed++; $display("FAIL stall_hold[%0d]: valid=%b data=%h ch=%0d expected 1/a1/1", k, out_valid, out_data, out_ch); end
    end
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 4'b0100) begin tests_failed++; $display("FAIL stall_release_ready: in_ready=%b expected 0100", in_ready); end
    tick();
    tests_run++; if (out_data !== 8'hA2 || out_ch !== 2'd2) begin tests_failed++; $display("FAIL stall_release_beat: data=%h ch=%0d expected a2/2", out_data, out_ch); end
  endtask

  task automatic test_prio();
    prio_mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++; if (in_ready !== 4'b0010) begin tests_failed++; $display("FAIL prio_ready[%0d]: in_ready=%b expected 0010", k, in_ready); end
      tick();
      tests_run++; if (out_ch !== 2'd1 || out_data !== 8'hA1) begin tests_failed++; $display("FAIL prio_beat[%0d]: ch=%0d data=%h expected 1/a1", k, out_ch, out_data); end
    end
    prio_mode = 1'b0;
    #1;
    tests_run++; if (in_ready !== 4'b1000) begin tests_failed++; $display("FAIL prio_to_rr_ready: in_ready=%b expected 1000", in_ready); end
    tick();
    tests_run++; if (out_ch !== 2'd3) begin tests_failed++; $display("FAIL prio_to_rr_beat: ch=%0d expected 3", out_ch); end
  endtask

  task automatic test_wrap();
    in_valid = 4'b0100;
    #1 tick();
    in_valid = 4'b0101;
    #1;
    tests_run++; if (in_ready !== 4'b0001) begin tests_failed++; $display("FAIL wrap_ready0: in_ready=%b expected 0001", in_ready); end
    tick();
    tests_run++; if (out_ch !== 2'd0) begin tests_failed++; $display("FAIL wrap_beat0: ch=%0d expected 0", out_ch); end
    #1;
    tests_run++; if (in_ready !== 4'b0100) begin tests_failed++; $display("FAIL wrap_ready2: in_ready=%b expected 0100", in_ready); end
    tick();
    tests_run++; if (out_ch !== 2'd2 || out_data !== 8'hA2) begin tests_failed++; $display("FAIL wrap_beat2: ch=%0d data=%h expected 2/a2", out_ch, out_data); end
  endtask

  task automatic test_idle();
    in_valid = 4'b0000; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++; if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL idle_ready[%0d]: in_ready=%b expected 0000", k, in_ready); end
      tick();
      tests_run++; if (out_valid !== 1'b0 || out_ch !== 2'd2 || out_data !== 8'hA2) begin tests_failed++; $display("FAIL idle_out[%0d]: valid=%b ch=%0d data=%h expected 0/2/a2", k, out_valid, out_ch, out_data); end
    end
    in_valid = 4'b1111;
    #1;
    tests_run++; if (in_ready !== 4'b1000) begin tests_failed++; $display("FAIL idle_ptr: in_ready=%b expected 1000", in_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_rdy;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) prio_mode = ~prio_mode;
      #1;
      exp_rdy = model_ready();
      tests_run++; if (in_ready !== exp_rdy) begin tests_failed++; $display("FAIL rand_ready[%0d]: in_ready=%b expected %b", k, in_ready, exp_rdy); end
      tick();
      tests_run++;
      if (out_valid !== m_full || out_data !== m_data || out_ch !== 2'(m_ch)) begin
        tests_failed++;
        $display("FAIL rand_out[%0d]: valid=%b data=%h ch=%0d expected %b/%h/%0d", k, out_valid, out_data, out_ch, m_full, m_data, m_ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_prio();
    test_wrap();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
